// File: rtl/p15_envelope_pkg.sv
// -----------------------------------------------------------------------------
// p15_envelope_pkg
//
// Shared definitions for the multi-channel envelope bank.
//   - Bit positions inside the 4-bit shape word {continue, attack, alternate, hold}.
//   - Decode helpers used by every envelope engine.
//
// Optional feature macro used by the files that import this package:
//   P15_ENVELOPE_BANK_DONE_EN  (adds the per-channel `done` pulse output)
// -----------------------------------------------------------------------------
package p15_envelope_pkg;

    localparam int SHAPE_W         = 4;
    localparam int SHAPE_CONTINUE  = 3;
    localparam int SHAPE_ATTACK    = 2;
    localparam int SHAPE_ALTERNATE = 1;
    localparam int SHAPE_HOLD      = 0;

    // Level a holding shape freezes at: MAX when the shape continues and the
    // last segment direction (attack flipped by alternate) is upward.
    function automatic logic hold_level_is_max(input logic [SHAPE_W-1:0] shape);
        return shape[SHAPE_CONTINUE] && (shape[SHAPE_ATTACK] ^ shape[SHAPE_ALTERNATE]);
    endfunction

    // A segment end freezes the channel for explicit hold, or for any
    // non-continuing shape (those always finish at level 0).
    function automatic logic segment_holds(input logic [SHAPE_W-1:0] shape);
        return shape[SHAPE_HOLD] || !shape[SHAPE_CONTINUE];
    endfunction

endpackage

// File: rtl/p15_envelope_channel.sv
// -----------------------------------------------------------------------------
// p15_envelope_channel
//
// One envelope engine: period prescaler, level counter and invert/held logic.
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset (out = MAX, held = 0)
//   enable    : prescaler clock-enable
//   period    : prescaler period (0 behaves as 1)
//   shape     : shape write data {continue, attack, alternate, hold}
//   shape_we  : load `shape` and restart the engine (not gated by enable)
//   out       : envelope level
//   held      : engine is frozen at its hold level
//   done      : one-cycle pulse at each segment end
//               (only with P15_ENVELOPE_BANK_DONE_EN defined)
// -----------------------------------------------------------------------------
module p15_envelope_channel
    import p15_envelope_pkg::*;
#(
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [PERIOD_BITS-1:0]   period,
    input  logic [SHAPE_W-1:0]       shape,
    input  logic                     shape_we,
    output logic [ENVELOPE_BITS-1:0] out,
    output logic                     held
`ifdef P15_ENVELOPE_BANK_DONE_EN
    ,
    output logic                     done
`endif
);

    localparam logic [ENVELOPE_BITS-1:0] MAX     = {ENVELOPE_BITS{1'b1}};
    localparam logic [ENVELOPE_BITS-1:0] ENV_ONE = ENVELOPE_BITS'(1);
    localparam logic [PERIOD_BITS-1:0]   PER_ONE = PERIOD_BITS'(1);

    logic [SHAPE_W-1:0]       shape_r;
    logic [PERIOD_BITS-1:0]   presc;
    logic [PERIOD_BITS-1:0]   presc_nxt;
    logic [PERIOD_BITS-1:0]   last_tick;
    logic [ENVELOPE_BITS-1:0] count;
    logic [ENVELOPE_BITS-1:0] count_nxt;
    logic                     invert;
    logic                     invert_nxt;
    logic                     held_r;
    logic                     held_nxt;
    logic                     wrap;
    logic                     step;
    logic                     seg_end;

    // Prescaler terminal value; period 0 is treated as period 1.
    always_comb begin
        if (period == '0) begin
            last_tick = '0;
        end else begin
            last_tick = period - PER_ONE;
        end
    end

    // `>=` rather than `==` so that lowering the period below the current
    // prescaler value issues the step on the next enabled cycle instead of
    // wrapping through the full counter range.
    assign wrap = (presc >= last_tick);

    // A shape write wins over a coincident step; a held engine ignores steps.
    assign step    = enable && wrap && !shape_we && !held_r;
    assign seg_end = step && (count == MAX);

    always_comb begin
        presc_nxt = wrap ? '0 : presc + PER_ONE;
    end

    // Level / direction / hold next-state for a step.
    always_comb begin
        count_nxt  = count;
        invert_nxt = invert;
        held_nxt   = held_r;
        if (step) begin
            if (count != MAX) begin
                count_nxt = count + ENV_ONE;
            end else if (segment_holds(shape_r)) begin
                // Freeze with count at MAX; invert selects which end is shown.
                held_nxt   = 1'b1;
                count_nxt  = MAX;
                invert_nxt = !hold_level_is_max(shape_r);
            end else begin
                count_nxt = '0;
                if (shape_r[SHAPE_ALTERNATE]) begin
                    invert_nxt = !invert;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shape_r <= '0;
            presc   <= '0;
            count   <= '0;
            invert  <= 1'b1;
            held_r  <= 1'b0;
        end else if (shape_we) begin
            // Restart: attack shapes start at 0, decay shapes at MAX.
            shape_r <= shape;
            presc   <= '0;
            count   <= '0;
            invert  <= !shape[SHAPE_ATTACK];
            held_r  <= 1'b0;
        end else begin
            if (enable) begin
                presc <= presc_nxt;
            end
            count  <= count_nxt;
            invert <= invert_nxt;
            held_r <= held_nxt;
        end
    end

    assign out  = invert ? (MAX - count) : count;
    assign held = held_r;

`ifdef P15_ENVELOPE_BANK_DONE_EN
    logic done_r;

    // seg_end already excludes held engines and shape-write cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= seg_end;
        end
    end

    assign done = done_r;
`else
    logic unused_seg_end;
    assign unused_seg_end = seg_end;
`endif

endmodule

// File: rtl/p15_envelope_bank.sv
// -----------------------------------------------------------------------------
// p15_envelope_bank
//
// Bank of CHANNELS independent envelope engines sitting between the register
// file (period / shape writes) and the per-channel amplitude mixers.
//
// Parameters
//   CHANNELS      : number of engines
//   PERIOD_BITS   : width of each per-channel period
//   ENVELOPE_BITS : output level width (MAX = 2^ENVELOPE_BITS - 1)
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   enable    : clock-enable shared by all prescalers
//   period    : channel c uses period[c*PERIOD_BITS +: PERIOD_BITS]
//   shape     : shared shape write data {continue, attack, alternate, hold}
//   shape_we  : per-channel write strobe; each set bit loads `shape` and restarts
//   out       : channel c level at out[c*ENVELOPE_BITS +: ENVELOPE_BITS]
//   held      : per-channel frozen-at-hold-level flag
//   done      : per-channel segment-end pulse
//               (only with P15_ENVELOPE_BANK_DONE_EN defined)
// -----------------------------------------------------------------------------
module p15_envelope_bank
    import p15_envelope_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [CHANNELS*PERIOD_BITS-1:0]   period,
    input  logic [SHAPE_W-1:0]                shape,
    input  logic [CHANNELS-1:0]               shape_we,
    output logic [CHANNELS*ENVELOPE_BITS-1:0] out,
    output logic [CHANNELS-1:0]               held
`ifdef P15_ENVELOPE_BANK_DONE_EN
    ,
    output logic [CHANNELS-1:0]               done
`endif
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        p15_envelope_channel #(
            .PERIOD_BITS   (PERIOD_BITS),
            .ENVELOPE_BITS (ENVELOPE_BITS)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .period   (period[c*PERIOD_BITS +: PERIOD_BITS]),
            .shape    (shape),
            .shape_we (shape_we[c]),
            .out      (out[c*ENVELOPE_BITS +: ENVELOPE_BITS]),
            .held     (held[c])
`ifdef P15_ENVELOPE_BANK_DONE_EN
            ,
            .done     (done[c])
`endif
        );
    end

endmodule

// File: tb/tb_p15_envelope_bank.sv
`timescale 1ns/1ps
module tb_p15_envelope_bank;

    localparam int CH = 3;
    localparam int PB = 16;
    localparam int EB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [CH*PB-1:0]  period;
    logic [3:0]        shape;
    logic [CH-1:0]     shape_we;
    logic [CH*EB-1:0]  out;
    logic [CH-1:0]     held;
`ifdef P15_ENVELOPE_BANK_DONE_EN
    logic [CH-1:0]     done;
`endif

    always #5 clk = ~clk;

    p15_envelope_bank #(
        .CHANNELS      (CH),
        .PERIOD_BITS   (PB),
        .ENVELOPE_BITS (EB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .period   (period),
        .shape    (shape),
        .shape_we (shape_we),
        .out      (out),
        .held     (held)
`ifdef P15_ENVELOPE_BANK_DONE_EN
        ,
        .done     (done)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CH*EB-1:0] out;
        logic [CH-1:0]    held;
        logic [CH-1:0]    done;
        logic [CH-1:0]    ok;
    } exp_t;

    exp_t sbq[$];

    // Reference model: per channel, shape / effective period / enabled edges since restart.
    int m_shape[CH];
    int m_p[CH];
    int m_n[CH];
    bit m_ok[CH];

    typedef struct {
        int ch;
        int per;
        int shp;
        int k;
        int exp_out;
        int exp_held;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_p(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    // Closed-form expected state after n enabled edges since restart.
    function automatic void model_level(input int s, input int p, input int n,
                                        output int lvl, output bit hd, output bit dn);
        int j;
        int seg;
        int c;
        bit inv;
        bit holds;
        j     = n / p;
        holds = s[0] || !s[3];
        dn    = (n > 0) && (n % p == 0) && (j % 16 == 0) && !(holds && j > 16);
        if (holds && j >= 16) begin
            hd  = 1'b1;
            lvl = (s[3] && (s[2] ^ s[1])) ? 15 : 0;
        end else begin
            hd  = 1'b0;
            seg = j / 16;
            c   = j % 16;
            inv = !s[2] ^ (s[1] & seg[0]);
            lvl = inv ? 15 - c : c;
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_shape[c] = 0;
            m_n[c]     = 0;
            m_p[c]     = eff_p(int'(period[c*PB +: PB]));
            m_ok[c]    = 1'b1;
        end
    endtask

    // One clock: advance model with the driven inputs, push expectation,
    // take the edge, then pop and compare away from the edge.
    task automatic tick();
        exp_t e;
        int   lvl;
        bit   hd;
        bit   dn;
        for (int c = 0; c < CH; c++) begin
            if (shape_we[c]) begin
                m_shape[c] = int'(shape);
                m_p[c]     = eff_p(int'(period[c*PB +: PB]));
                m_n[c]     = 0;
                m_ok[c]    = 1'b1;
            end else if (enable) begin
                m_n[c]++;
            end
            model_level(m_shape[c], m_p[c], m_n[c], lvl, hd, dn);
            e.out[c*EB +: EB] = EB'(lvl);
            e.held[c]         = hd;
            e.done[c]         = dn;
            e.ok[c]           = m_ok[c];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        for (int c = 0; c < CH; c++) begin
            if (e.ok[c]) begin
                check($sformatf("sb_out ch%0d", c), 64'(out[c*EB +: EB]), 64'(e.out[c*EB +: EB]));
                check($sformatf("sb_held ch%0d", c), 64'(held[c]), 64'(e.held[c]));
`ifdef P15_ENVELOPE_BANK_DONE_EN
                check($sformatf("sb_done ch%0d", c), 64'(done[c]), 64'(e.done[c]));
`endif
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s out ch%0d", tag, c), 64'(out[c*EB +: EB]), 64'd15);
            check($sformatf("%s held ch%0d", tag, c), 64'(held[c]), 64'd0);
`ifdef P15_ENVELOPE_BANK_DONE_EN
            check($sformatf("%s done ch%0d", tag, c), 64'(done[c]), 64'd0);
`endif
        end
    endtask

    initial begin
        int pulses;

        // Hand-derived spot checks: {ch, period, shape, edges after write, out, held}
        tbl.push_back('{0, 2, 4'h9,   0, 15, 0});
        tbl.push_back('{0, 2, 4'h9,   1, 15, 0});
        tbl.push_back('{0, 2, 4'h9,   2, 14, 0});
        tbl.push_back('{0, 2, 4'h9,  30,  0, 0});
        tbl.push_back('{0, 2, 4'h9,  32,  0, 1});
        tbl.push_back('{0, 2, 4'h9, 132,  0, 1});
        tbl.push_back('{1, 1, 4'hE,   0,  0, 0});
        tbl.push_back('{1, 1, 4'hE,  15, 15, 0});
        tbl.push_back('{1, 1, 4'hE,  16, 15, 0});
        tbl.push_back('{1, 1, 4'hE,  17, 14, 0});
        tbl.push_back('{1, 1, 4'hE,  31,  0, 0});
        tbl.push_back('{1, 1, 4'hE,  33,  1, 0});
        tbl.push_back('{2, 0, 4'hC,   0,  0, 0});
        tbl.push_back('{2, 0, 4'hC,   1,  1, 0});
        tbl.push_back('{2, 0, 4'hC,  15, 15, 0});
        tbl.push_back('{2, 0, 4'hC,  16,  0, 0});
        tbl.push_back('{2, 0, 4'hC,  17,  1, 0});
        tbl.push_back('{0, 1, 4'hB,   0, 15, 0});
        tbl.push_back('{0, 1, 4'hB,  15,  0, 0});
        tbl.push_back('{0, 1, 4'hB,  16, 15, 1});
        tbl.push_back('{0, 1, 4'hB,  40, 15, 1});
        tbl.push_back('{0, 1, 4'h4,   0,  0, 0});
        tbl.push_back('{0, 1, 4'h4,  15, 15, 0});
        tbl.push_back('{0, 1, 4'h4,  16,  0, 1});
        tbl.push_back('{1, 3, 4'hC,   2,  0, 0});
        tbl.push_back('{1, 3, 4'hC,   3,  1, 0});

        // Reset state
        reset    = 1'b1;
        enable   = 1'b0;
        shape    = 4'h0;
        shape_we = '0;
        period   = '0;
        period[0*PB +: PB] = 16'd2;
        period[1*PB +: PB] = 16'd1;
        period[2*PB +: PB] = 16'd0;
        #3;
        check_reset_state("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        model_reset();

        // Reset-state shape 0 steps as a decay that holds at 0.
        repeat (10) tick();
        check("post_reset ch1 out", 64'(out[1*EB +: EB]), 64'd5);

        // Enable low freezes every prescaler.
        enable = 1'b0;
        repeat (5) tick();
        check("freeze ch1 out", 64'(out[1*EB +: EB]), 64'd5);
        check("freeze ch0 out", 64'(out[0*EB +: EB]), 64'd10);
        enable = 1'b1;
        repeat (30) tick();

        // Table-driven shape / period vectors
        for (int i = 0; i < tbl.size(); i++) begin
            period[tbl[i].ch*PB +: PB] = PB'(tbl[i].per);
            shape    = 4'(tbl[i].shp);
            shape_we = CH'(1 << tbl[i].ch);
            tick();
            shape_we = '0;
            repeat (tbl[i].k) tick();
            check($sformatf("vec%0d out", i), 64'(out[tbl[i].ch*EB +: EB]), 64'(tbl[i].exp_out));
            check($sformatf("vec%0d held", i), 64'(held[tbl[i].ch]), 64'(tbl[i].exp_held));
        end

        // Rewrite on the same edge as a due step: step discarded, restart wins.
        period[0*PB +: PB] = 16'd2;
        shape    = 4'hC;
        shape_we = 3'b001;
        tick();
        shape_we = '0;
        repeat (3) tick();
        check("prio before out0", 64'(out[0*EB +: EB]), 64'd1);
        shape_we = 3'b001;
        tick();
        shape_we = '0;
        check("prio restart out0", 64'(out[0*EB +: EB]), 64'd0);
        tick();
        check("prio presc0 out0", 64'(out[0*EB +: EB]), 64'd0);
        tick();
        check("prio first step out0", 64'(out[0*EB +: EB]), 64'd1);

        // Period lowered below the running prescaler value.
        period[2*PB +: PB] = 16'd10;
        shape    = 4'hC;
        shape_we = 3'b100;
        tick();
        shape_we = '0;
        repeat (5) tick();
        check("lower before out2", 64'(out[2*EB +: EB]), 64'd0);
        m_ok[2] = 1'b0;
        period[2*PB +: PB] = 16'd3;
        tick();
        check("lower step out2", 64'(out[2*EB +: EB]), 64'd1);
        repeat (2) tick();
        check("lower hold out2", 64'(out[2*EB +: EB]), 64'd1);
        tick();
        check("lower next out2", 64'(out[2*EB +: EB]), 64'd2);

        // Multi-channel write: both selected channels load the same shape.
        period[0*PB +: PB] = 16'd1;
        period[2*PB +: PB] = 16'd1;
        shape    = 4'hC;
        shape_we = 3'b101;
        tick();
        shape_we = '0;
        repeat (7) tick();
        check("multi out0", 64'(out[0*EB +: EB]), 64'd7);
        check("multi out2", 64'(out[2*EB +: EB]), 64'd7);

        // Asynchronous reset between edges, mid-segment.
        period[1*PB +: PB] = 16'd1;
        shape    = 4'h8;
        shape_we = 3'b010;
        tick();
        shape_we = '0;
        repeat (20) tick();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Repeating decay on ch1: segment end every 16 cycles.
        shape    = 4'h8;
        shape_we = 3'b010;
        tick();
        shape_we = '0;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
`ifdef P15_ENVELOPE_BANK_DONE_EN
            if (done[1] === 1'b1) pulses++;
`endif
        end
`ifdef P15_ENVELOPE_BANK_DONE_EN
        check("done pulse count ch1", 64'(pulses), 64'd2);
`endif
        check("saw end out1", 64'(out[1*EB +: EB]), 64'd15);
        check("saw end held1", 64'(held[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
